instr_fetch_ctrl: RTL and testbench

Sequencer that owns the instruction memory port. It arbitrates between a host program-load channel and the execution engine's fetch path. It loads instruction words into memory, then fetches them sequentially, or to a redirected jump address, and presents each word to the execution engine over a valid/ready handshake. It sits between the host/test loader, the instruction memory and the exe_engine.

---
 rtl/instr_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction memory sequencer: host load channel plus sequential fetch
// with jump redirect, issuing words to the exe engine over valid/ready.
module instr_fetch_ctrl #(
  parameter int DEPTH  = 10,
  parameter int DATA_W = 26,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic              halt_req,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] mem_pointer,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH, S_WAIT, S_ISSUE, S_DONE
  } state_t;

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  state_t state, nxt;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [DATA_W-1:0] ld_data_q;
  logic              rdy;

  logic            ld_ok;
  logic            go;
  logic            xfer;
  logic            jerr;
  logic            last;
  logic [ADDR_W:0] inc;

  assign ld_ok = ld_valid && ({1'b0, ld_addr} < LIMIT);
  assign go    = start && !ld_valid;
  assign xfer  = (state == S_ISSUE) && instr_ready && !halt_req;
  assign inc   = {1'b0, pc} + 1'b1;
  assign jerr  = jump_valid && ({1'b0, jump_addr} >= LIMIT);
  assign last  = !jump_valid && (inc >= LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (ld_valid) nxt = ld_ok ? S_LOAD : S_IDLE;
        else if (start) nxt = S_FETCH;
      end
      S_LOAD:  nxt = S_IDLE;
      S_FETCH: nxt = halt_req ? S_DONE : S_WAIT;
      S_WAIT:  nxt = halt_req ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (halt_req) nxt = S_DONE;
        else if (instr_ready)
          nxt = (jerr || last) ? S_DONE : S_FETCH;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_pointer = '0;
    unique case (state)
      S_LOAD:          mem_pointer = ld_addr_q;
      S_FETCH, S_WAIT: mem_pointer = pc;
      default:         mem_pointer = '0;
    endcase
  end

  assign mem_write   = (state == S_LOAD);
  assign mem_read    = (state == S_FETCH);
  assign mem_wdata   = mem_write ? ld_data_q : '0;
  assign instr_valid = (state == S_ISSUE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign ld_ready    = rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      ld_addr_q <= '0;
      ld_data_q <= '0;
      instr     <= '0;
      instr_pc  <= '0;
      err       <= 1'b0;
      rdy       <= 1'b0;
    end else begin
      rdy <= (nxt == S_IDLE);
      if (state == S_IDLE) begin
        if (ld_ok) begin
          ld_addr_q <= ld_addr;
          ld_data_q <= ld_data;
        end
        if (ld_valid && !ld_ok) err <= 1'b1;
        else if (go) begin
          err <= 1'b0;
          pc  <= '0;
        end
      end
      // Read data arrives the cycle after the FETCH strobe.
      if (state == S_WAIT && !halt_req) begin
        instr    <= mem_rdata;
        instr_pc <= pc;
      end
      if (xfer) begin
        if (jerr) err <= 1'b1;
        else if (!last)
          pc <= jump_valid ? jump_addr : inc[ADDR_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a small instruction memory
// model and hand-computed expectations.
module tb_instr_fetch_ctrl;

  localparam int DW = 26;
  localparam int AW = 4;

  logic          clk = 0;
  logic          reset = 1;
  logic          ld_valid = 0;
  logic          ld_ready;
  logic [AW-1:0] ld_addr = 0;
  logic [DW-1:0] ld_data = 0;
  logic          start = 0;
  logic          halt_req = 0;
  logic          jump_valid = 0;
  logic [AW-1:0] jump_addr = 0;
  logic          instr_valid;
  logic          instr_ready = 0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic [AW-1:0] mem_pointer;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 0;
  logic          busy;
  logic          done;
  logic          err;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int both_cnt = 0;
  int done_cnt = 0;

  logic [DW-1:0] mem [16];

  always #5 clk = ~clk;

  instr_fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .halt_req(halt_req),
    .jump_valid(jump_valid), .jump_addr(jump_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .mem_pointer(mem_pointer), .mem_write(mem_write),
    .mem_read(mem_read), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy),
    .done(done), .err(err)
  );

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_pointer] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read) begin
      mem_rdata <= mem[mem_pointer];
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_valid = 1; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 0;
    chk("ld_wr", 32'(mem_write), 1);
    chk("ld_ptr", 32'(mem_pointer), 32'(a));
    chk("ld_wd", 32'(mem_wdata), 32'(d));
    chk("ld_rdy0", 32'(ld_ready), 0);
    chk("ld_rd", 32'(mem_read), 0);
    tick();
    chk("ld_wr_end", 32'(mem_write), 0);
    chk("ld_rdy1", 32'(ld_ready), 1);
  endtask

  task automatic kick();
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    int w0, r0, d0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rdy", 32'(ld_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_strb", 32'({mem_write, mem_read}), 0);
    reset = 0;
    tick();
    chk("post_rst_rdy", 32'(ld_ready), 1);

    // Load path
    load(0, 26'h0000001);
    load(1, 26'h0000002);
    load(2, 26'h0000003);
    chk("ld_rdcnt", 32'(rd_cnt), 0);
    chk("ld_mem2", 32'(mem[2]), 32'h3);

    // Sequential run
    for (int i = 0; i < 10; i++) load(AW'(i), DW'(26'h100 + i));
    instr_ready = 1;
    d0 = done_cnt;
    kick();
    chk("seq_fetch_rd", 32'(mem_read), 1);
    chk("seq_fetch_ptr", 32'(mem_pointer), 0);
    chk("seq_v0a", 32'(instr_valid), 0);
    tick();
    chk("seq_v0b", 32'(instr_valid), 0);
    chk("seq_wait_rd", 32'(mem_read), 0);
    tick();
    chk("seq_v1", 32'(instr_valid), 1);
    chk("seq_i0", 32'(instr), 32'h100);
    chk("seq_pc0", 32'(instr_pc), 0);
    for (int i = 1; i < 10; i++) begin
      repeat (3) tick();
      chk("seq_v", 32'(instr_valid), 1);
      chk("seq_i", 32'(instr), 32'h100 + 32'(i));
      chk("seq_pc", 32'(instr_pc), 32'(i));
    end
    tick();
    chk("seq_done", 32'(done), 1);
    chk("seq_rd_done", 32'(mem_read), 0);
    tick();
    chk("seq_done_end", 32'(done), 0);
    chk("seq_busy", 32'(busy), 0);
    chk("seq_done_cnt", 32'(done_cnt - d0), 1);

    // Backpressure
    instr_ready = 0;
    kick();
    repeat (2) tick();
    r0 = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_v", 32'(instr_valid), 1);
      chk("bp_i", 32'(instr), 32'h100);
      chk("bp_pc", 32'(instr_pc), 0);
      chk("bp_rd", 32'(mem_read), 0);
    end
    chk("bp_rdcnt", 32'(rd_cnt - r0), 0);
    instr_ready = 1;
    tick();
    chk("bp_rel_rd", 32'(mem_read), 1);
    chk("bp_rel_ptr", 32'(mem_pointer), 1);
    repeat (2) tick();
    chk("bp_pc1", 32'(instr_pc), 1);

    // Jump from pc 1 to 4, then out of range
    jump_valid = 1; jump_addr = 4;
    tick();
    jump_valid = 0;
    chk("jmp_ptr", 32'(mem_pointer), 4);
    repeat (2) tick();
    chk("jmp_pc", 32'(instr_pc), 4);
    chk("jmp_i", 32'(instr), 32'h104);
    jump_valid = 1; jump_addr = 12;
    r0 = rd_cnt;
    tick();
    jump_valid = 0;
    chk("jbad_done", 32'(done), 1);
    chk("jbad_err", 32'(err), 1);
    tick();
    chk("jbad_idle", 32'(busy), 0);
    repeat (2) tick();
    chk("jbad_norl", 32'(rd_cnt - r0), 0);
    chk("jbad_sticky", 32'(err), 1);

    // Start clears err; halt in FETCH
    instr_ready = 0;
    kick();
    chk("clr_err", 32'(err), 0);
    halt_req = 1;
    tick();
    halt_req = 0;
    chk("halt_done", 32'(done), 1);
    tick();

    // Range error and load/start priority
    w0 = wr_cnt;
    ld_valid = 1; ld_addr = 10; ld_data = 26'h3ff;
    tick();
    ld_valid = 0;
    chk("rng_err", 32'(err), 1);
    chk("rng_wr", 32'(mem_write), 0);
    chk("rng_busy", 32'(busy), 0);
    chk("rng_wcnt", 32'(wr_cnt - w0), 0);
    r0 = rd_cnt;
    ld_valid = 1; ld_addr = 3; ld_data = 26'h2a5a5a5;
    start = 1;
    tick();
    ld_valid = 0; start = 0;
    chk("pri_wr", 32'(mem_write), 1);
    chk("pri_ptr", 32'(mem_pointer), 3);
    tick();
    chk("pri_busy", 32'(busy), 0);
    tick();
    chk("pri_nofetch", 32'(rd_cnt - r0), 0);
    chk("pri_mem3", 32'(mem[3]), 32'h2a5a5a5);
    chk("pri_err", 32'(err), 1);

    // Reset during WAIT
    kick();
    tick();
    #2 reset = 1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_strb", 32'({mem_read, mem_write, instr_valid}), 0);
    chk("arst_ptr", 32'(mem_pointer), 0);
    chk("arst_rdy", 32'(ld_ready), 0);
    chk("arst_instr", 32'(instr), 0);
    chk("arst_err", 32'(err), 0);
    @(negedge clk);
    reset = 0;
    tick();
    chk("arst_rdy1", 32'(ld_ready), 1);
    kick();
    chk("arst_ptr0", 32'(mem_pointer), 0);
    chk("arst_rd", 32'(mem_read), 1);
    repeat (2) tick();
    chk("arst_v", 32'(instr_valid), 1);
    chk("arst_i", 32'(instr), 32'h100);
    halt_req = 1;
    tick();
    halt_req = 0;
    chk("issue_halt_v", 32'(instr_valid), 0);
    chk("issue_halt_d", 32'(done), 1);
    tick();
    chk("overlap", 32'(both_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
